// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: data port has priority over fetch, a bounded data
// streak forces a pending fetch through, and a watchdog aborts stuck accesses.
module ram_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        bus_error
);

  localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, INSTR = 2'd2} state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [SW-1:0] dstreak_r;
  logic [7:0]    tcnt_r;

  logic dreq_s;
  logic streak_block_s;
  logic grant_d_s;
  logic grant_i_s;
  logic busy_s;
  logic timeout_s;
  logic done_s;
  logic i_done_s;
  logic d_done_s;

  assign dreq_s         = dREN | dWEN;
  assign streak_block_s = iREN && (dstreak_r == SW'(MAX_DSTREAK));
  assign grant_d_s      = (state_r == IDLE) && dreq_s && !streak_block_s;
  assign grant_i_s      = (state_r == IDLE) && !grant_d_s && iREN;
  assign busy_s         = (state_r != IDLE);
  // ram_ready beats the watchdog when both land on the same cycle
  assign timeout_s      = busy_s && !ram_ready && (tcnt_r == 8'(TIMEOUT));
  assign done_s         = busy_s && (ram_ready || timeout_s);
  assign i_done_s       = iREN && (state_r == INSTR) && done_s;
  assign d_done_s       = dreq_s && (state_r == DATA) && done_s;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          next_state_s = DATA;
        end else if (grant_i_s) begin
          next_state_s = INSTR;
        end else begin
          next_state_s = IDLE;
        end
      end
      DATA, INSTR: begin
        if (done_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Latched RAM command, streak counter, watchdog and sticky error flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      ramREN    <= 1'b0;
      ramWEN    <= 1'b0;
      ramaddr   <= 32'h0;
      ramstore  <= 32'h0;
      dstreak_r <= '0;
      tcnt_r    <= 8'd0;
      bus_error <= 1'b0;
    end else begin
      if (grant_d_s) begin
        ramREN   <= !dWEN;
        ramWEN   <= dWEN;
        ramaddr  <= daddr;
        ramstore <= dstore;
      end else if (grant_i_s) begin
        ramREN   <= 1'b1;
        ramWEN   <= 1'b0;
        ramaddr  <= iaddr;
      end else if (done_s) begin
        ramREN   <= 1'b0;
        ramWEN   <= 1'b0;
      end

      // Any IDLE cycle that is not a data grant with fetch waiting ends the streak
      if (state_r == IDLE) begin
        if (grant_d_s && iREN) begin
          dstreak_r <= (dstreak_r == SW'(MAX_DSTREAK)) ? dstreak_r : dstreak_r + SW'(1);
        end else begin
          dstreak_r <= '0;
        end
      end

      if (grant_d_s || grant_i_s) begin
        tcnt_r <= 8'd0;
      end else if (busy_s && !done_s) begin
        tcnt_r <= tcnt_r + 8'd1;
      end

      if (timeout_s) begin
        bus_error <= 1'b1;
      end
    end
  end

  // Stall and load outputs; loads pass RAM data straight through on completion
  always_comb begin
    iwait = iREN && !((state_r == INSTR) && done_s);
    dwait = dreq_s && !((state_r == DATA) && done_s);
    if (i_done_s) begin
      iload = ram_ready ? ramload : 32'hDEADBEEF;
    end else begin
      iload = 32'h0;
    end
    if (d_done_s) begin
      dload = ram_ready ? ramload : 32'hDEADBEEF;
    end else begin
      dload = 32'h0;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: requesters push expected completions,
// a negedge monitor pops and compares whenever a port's wait drops.
module tb_ram_arbiter;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;
  logic        bus_error;

  ram_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .bus_error(bus_error)
  );

  typedef struct {
    bit          kind;   // 0 = fetch, 1 = data
    logic [31:0] addr;
    bit          wen;
    logic [31:0] store;
    logic [31:0] load;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;
  int   lat;
  bit   ram_hang;
  int   cnt;
  logic [31:0] mem [logic [31:0]];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit kind, input logic [31:0] addr, input bit wen,
                      input logic [31:0] store, input logic [31:0] load);
    exp_t e;
    e.kind = kind; e.addr = addr; e.wen = wen; e.store = store; e.load = load;
    exp_q.push_back(e);
  endtask

  // Caller is at posedge+2; returns at posedge+2 of the cycle after completion
  task automatic fetch(input logic [31:0] a, output int n);
    iREN = 1'b1; iaddr = a; n = 0;
    while (1) begin
      @(negedge CLK); n++;
      if (!iwait) break;
      if (n >= 400) begin
        tests++; fails++;
        $display("FAIL fetch_wait: no completion after %0d cycles", n);
        break;
      end
    end
    @(posedge CLK); #2;
    iREN = 1'b0;
  endtask

  task automatic dacc(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] s, output int n);
    dREN = rd; dWEN = wr; daddr = a; dstore = s; n = 0;
    while (1) begin
      @(negedge CLK); n++;
      if (!dwait) break;
      if (n >= 400) begin
        tests++; fails++;
        $display("FAIL data_wait: no completion after %0d cycles", n);
        break;
      end
    end
    @(posedge CLK); #2;
    dREN = 1'b0; dWEN = 1'b0;
  endtask

  // RAM model: ready after lat cycles of a held strobe, unless hung
  always @(posedge CLK) begin
    if (ram_ready && ramWEN) mem[ramaddr] = ramstore;
    #1;
    if ((ramREN || ramWEN) && !ram_hang && cnt == lat) begin
      ram_ready = 1'b1;
      ramload   = mem.exists(ramaddr) ? mem[ramaddr] : ~ramaddr;
    end else begin
      ram_ready = 1'b0;
      ramload   = 32'h0;
    end
    if (ramREN || ramWEN) cnt++;
    else cnt = 0;
  end

  // Monitor: pop and compare on every completion
  always @(negedge CLK) begin : mon
    bit   ic;
    bit   dc;
    exp_t e;
    ic = iREN && !iwait;
    dc = (dREN || dWEN) && !dwait;
    if (!RST && (ic || dc)) begin
      check("single_owner", {31'd0, ic && dc}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_completion: got owner %0d expected none", dc);
      end else begin
        e = exp_q.pop_front();
        check("owner", {31'd0, dc}, {31'd0, e.kind});
        check("ramaddr", ramaddr, e.addr);
        check("ramWEN", {31'd0, ramWEN}, {31'd0, e.wen});
        check("ramREN", {31'd0, ramREN}, {31'd0, !e.wen});
        if (e.wen) check("ramstore", ramstore, e.store);
        else if (ic) check("iload", iload, e.load);
        else check("dload", dload, e.load);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, n1, n2;
    RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
    ram_ready = 1'b0; ramload = 32'h0; lat = 0; ram_hang = 1'b0; cnt = 0;
    tests = 0; fails = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_iwait", {31'd0, iwait}, 32'd1);
    check("rst_dwait", {31'd0, dwait}, 32'd1);
    check("rst_ramREN", {31'd0, ramREN}, 32'd0);
    check("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_ramstore", ramstore, 32'h0);
    check("rst_iload", iload, 32'h0);
    check("rst_dload", dload, 32'h0);
    check("rst_bus_error", {31'd0, bus_error}, 32'd0);
    @(posedge CLK); #2;
    RST = 1'b0; iREN = 1'b0; dREN = 1'b0;
    @(posedge CLK); #2;

    // Lone fetch, ready two cycles after grant
    lat = 2; mem[32'h40] = 32'h8C010004;
    push(1'b0, 32'h40, 1'b0, 32'h0, 32'h8C010004);
    fetch(32'h40, n);
    check("lone_latency", n, 32'd4);

    // Minimum latency
    lat = 0; mem[32'h44] = 32'h12345678;
    push(1'b0, 32'h44, 1'b0, 32'h0, 32'h12345678);
    fetch(32'h44, n);
    check("min_latency", n, 32'd2);

    // Simultaneous fetch and store: data first
    lat = 1; mem[32'h48] = 32'h0000BEEF;
    push(1'b1, 32'h100, 1'b1, 32'hCAFE0001, 32'h0);
    push(1'b0, 32'h48, 1'b0, 32'h0, 32'h0000BEEF);
    fork
      fetch(32'h48, n1);
      dacc(1'b0, 1'b1, 32'h100, 32'hCAFE0001, n2);
    join
    check("simul_fetch_latency", n1, 32'd6);
    push(1'b1, 32'h100, 1'b0, 32'h0, 32'hCAFE0001);
    dacc(1'b1, 1'b0, 32'h100, 32'h0, n);

    // dREN and dWEN together behave as a write
    lat = 0;
    push(1'b1, 32'h200, 1'b1, 32'h11112222, 32'h0);
    dacc(1'b1, 1'b1, 32'h200, 32'h11112222, n);
    push(1'b1, 32'h200, 1'b0, 32'h0, 32'h11112222);
    dacc(1'b1, 1'b0, 32'h200, 32'h0, n);

    // Starvation: four data grants, then the fetch, then data resumes
    push(1'b1, 32'h300, 1'b0, 32'h0, 32'hFFFFFCFF);
    push(1'b1, 32'h304, 1'b0, 32'h0, 32'hFFFFFCFB);
    push(1'b1, 32'h308, 1'b0, 32'h0, 32'hFFFFFCF7);
    push(1'b1, 32'h30C, 1'b0, 32'h0, 32'hFFFFFCF3);
    push(1'b0, 32'h50,  1'b0, 32'h0, 32'hFFFFFFAF);
    push(1'b1, 32'h310, 1'b0, 32'h0, 32'hFFFFFCEF);
    push(1'b1, 32'h314, 1'b0, 32'h0, 32'hFFFFFCEB);
    fork
      fetch(32'h50, n1);
      begin
        for (int k = 0; k < 6; k++) dacc(1'b1, 1'b0, 32'h300 + 32'(4 * k), 32'h0, n2);
      end
    join
    check("starve_fetch_latency", n1, 32'd10);

    // Watchdog abort, then sticky bus_error
    ram_hang = 1'b1;
    push(1'b1, 32'h400, 1'b0, 32'h0, 32'hDEADBEEF);
    dacc(1'b1, 1'b0, 32'h400, 32'h0, n);
    check("timeout_latency", n, 32'd257);
    check("bus_error_set", {31'd0, bus_error}, 32'd1);
    ram_hang = 1'b0; lat = 0;
    push(1'b0, 32'h44, 1'b0, 32'h0, 32'h12345678);
    fetch(32'h44, n);
    check("bus_error_sticky", {31'd0, bus_error}, 32'd1);

    // Reset in the third cycle of an INSTR access
    ram_hang = 1'b1; iREN = 1'b1; iaddr = 32'h80;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    @(posedge CLK); #2;
    RST = 1'b0;
    check("rstmid_ramREN", {31'd0, ramREN}, 32'd0);
    check("rstmid_bus_error", {31'd0, bus_error}, 32'd0);
    check("rstmid_iwait", {31'd0, iwait}, 32'd1);
    ram_hang = 1'b0; lat = 1; mem[32'h80] = 32'hA5A5A5A5;
    push(1'b0, 32'h80, 1'b0, 32'h0, 32'hA5A5A5A5);
    fetch(32'h80, n);
    check("rstmid_refetch_latency", n, 32'd3);

    repeat (2) @(posedge CLK);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Single-port RAM arbiter sharing one memory port between the fetch stage (instruction reads) and the memory stage (data reads and writes). Data requests have priority, so a stalled load or store always drains. A bounded-streak rule keeps fetch from being starved. A watchdog aborts any RAM access that never completes. The block sits between the pipeline's memory-facing ports and the RAM model, and drives the wait signals that stall the pipeline.

## Interface
Parameters
- `MAX_DSTREAK`, default 4: consecutive data grants allowed while a fetch is pending before fetch is forced through.
- `TIMEOUT`, default 255: cycles a granted access may wait for `ram_ready` before it is aborted. Counter is 8 bits.

Ports
- `CLK`, in, 1: clock. All state updates on the rising edge.
- `RST`, in, 1: reset. Synchronous, active-high.
- `iREN`, in, 1: fetch read request. Held until `iwait` is low.
- `iaddr`, in, 32: fetch address.
- `iload`, out, 32: fetched word. Valid when `iREN && !iwait`.
- `iwait`, out, 1: fetch stall.
- `dREN`, in, 1: data read request.
- `dWEN`, in, 1: data write request. Overrides `dREN` if both are high.
- `daddr`, in, 32: data address.
- `dstore`, in, 32: write data.
- `dload`, out, 32: read data. Valid when `dREN && !dwait`.
- `dwait`, out, 1: data stall.
- `ramREN`, out, 1: RAM read request.
- `ramWEN`, out, 1: RAM write request.
- `ramaddr`, out, 32: RAM address.
- `ramstore`, out, 32: RAM write data.
- `ramload`, in, 32: RAM read data.
- `ram_ready`, in, 1: RAM access complete this cycle.
- `bus_error`, out, 1: sticky timeout flag. Cleared only by reset.

## Operation
- States: IDLE, DATA, INSTR.
- IDLE:
  - If `dREN|dWEN` and the streak rule is not blocking: latch `daddr`, `dstore` and op (write if `dWEN`), go to DATA.
  - Else if `iREN`: latch `iaddr`, go to INSTR.
  - Else stay in IDLE.
- Streak rule:
  - `dstreak` increments on each data grant made while `iREN=1`, saturating at `MAX_DSTREAK`.
  - It clears on an instruction grant, and on any IDLE cycle with `iREN=0`.
  - When `dstreak==MAX_DSTREAK` and `iREN=1`, IDLE grants INSTR even if data is pending.
- DATA/INSTR:
  - `ramREN`/`ramWEN` and `ramaddr`/`ramstore` are driven from the latched registers, never from live inputs.
  - When `ram_ready=1`: the owner's wait is low that same cycle, and load = `ramload` (combinational pass-through). Next state is IDLE.
- Watchdog:
  - `tcnt` clears on entry to DATA/INSTR and increments each cycle without `ram_ready`.
  - When `tcnt==TIMEOUT`: abort the access. The owner's wait goes low that cycle with load = 32'hDEADBEEF, `bus_error` is set, next state is IDLE.
- Waits:
  - `iwait = iREN && !(state==INSTR && (ram_ready || timeout))`.
  - `dwait = (dREN|dWEN) && !(state==DATA && (ram_ready || timeout))`.
- `iload`/`dload` are 0 when their completion condition is false.
- `ramREN`/`ramWEN` are both 0 in IDLE. They are never both 1.

## Timing
- Reset values: state IDLE, `dstreak=0`, `tcnt=0`, `bus_error=0`, `ramREN=ramWEN=0`, `ramaddr=ramstore=0`, `iload=dload=0`.
  - `iwait`/`dwait` follow their requests and stay high, since no completion is possible in IDLE.
- Minimum latency: request seen in IDLE at cycle 0 → grant state at cycle 1 → wait low at cycle 1 if `ram_ready`.
  - Every transaction costs at least 2 cycles, with one IDLE cycle between back-to-back transactions.
- Request dropped mid-access: the access still runs to completion or timeout, and the result is discarded.
  - Requesters must not do this; the bench checks only that no hang results.
- `RST` asserted in DATA/INSTR: next edge goes to IDLE with RAM strobes low. The aborted requester stays stalled until it is re-granted.
- Timeout on the exact cycle `ram_ready` rises: `ram_ready` wins, normal completion, `bus_error` unchanged.

## Test plan
- Lone fetch: `iREN=1`, `iaddr=0x40`, `ram_ready` 2 cycles after grant, `ramload=0x8C010004` → `iwait` low for one cycle with `iload=0x8C010004`, `ramaddr=0x40`, `ramREN=1`, `ramWEN=0`.
- Simultaneous requests: `iREN` and `dWEN` (`daddr=0x100`, `dstore=0xCAFE0001`) in the same IDLE cycle → DATA granted first with `ramWEN=1`, `ramstore=0xCAFE0001`; fetch is granted in the next transaction.
- Starvation: `iREN` held, data request always pending, `MAX_DSTREAK=4` → exactly 4 data grants, then 1 INSTR grant, then data resumes.
- Timeout: grant a data read, `ram_ready` held 0 → `dwait` low after 256 cycles in DATA with `dload=0xDEADBEEF`; `bus_error=1` and stays 1 through later successful accesses until `RST`.
- Reset mid-access: `RST` pulsed at the 3rd cycle of an INSTR access → next cycle `ramREN=0`, state IDLE, `bus_error=0`; the re-issued fetch completes normally.
- `dREN` and `dWEN` both high → `ramWEN=1`, `ramREN=0`.
